// File: rtl/oserdes_pkg.sv
// ---------------------------------------------------------------------------
// oserdes_pkg
//   Shared definitions for the oserdes serializer family.
//   - state_t    : packet loader FSM states
//   - LEN_W      : width of packet length / serializer buffer pointers
//   - DRAIN_W    : width of the drain countdown (max length + guard gap)
//   - DEF_*      : default loader parameters
// ---------------------------------------------------------------------------
package oserdes_pkg;

  localparam int LEN_W         = 8;
  localparam int DRAIN_W       = 9;
  localparam int DEF_MAX_LEN   = 255;
  localparam int DEF_DRAIN_GAP = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    DISCARD = 3'd2,
    LAUNCH  = 3'd3,
    DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/oserdes_pkt_loader.sv
// ---------------------------------------------------------------------------
// oserdes_pkt_loader
//   Framing stage in front of the oserdes serializer. Takes a valid/ready/last
//   byte stream, copies each packet's bytes into the serializer buffer, then
//   fires one start pulse carrying the packet length. Input is held off until
//   the serializer has drained the packet plus DRAIN_GAP idle cycles, so only
//   one packet is ever in flight in the serializer buffer.
//
// Ports
//   wr_clk        in   clock (serializer parallel clock)
//   wr_rst        in   asynchronous active-high reset
//   s_data        in   [7:0] input byte
//   s_valid       in   input byte valid
//   s_last        in   byte is last of its packet
//   s_ready       out  loader accepts a byte this cycle
//   ser_data_o    out  [7:0] byte to serializer data_in
//   ser_valid_o   out  serializer data_valid_in
//   ser_start_o   out  one-cycle start pulse to serializer
//   ser_length_o  out  [7:0] packet length, stable from start to next start
//   busy_o        out  loader not idle
//   trunc_err_o   out  one-cycle pulse: packet reached MAX_LEN without s_last
//   pkt_cnt_o     out  [CNT_W-1:0] packets launched, wraps
// ---------------------------------------------------------------------------
module oserdes_pkt_loader
  import oserdes_pkg::*;
#(
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int DRAIN_GAP = DEF_DRAIN_GAP,
  parameter int CNT_W     = 16
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [7:0]        ser_data_o,
  output logic              ser_valid_o,
  output logic              ser_start_o,
  output logic [LEN_W-1:0]  ser_length_o,
  output logic              busy_o,
  output logic              trunc_err_o,
  output logic [CNT_W-1:0]  pkt_cnt_o
);

  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [DRAIN_W-1:0] GAP_L     = DRAIN_W'(DRAIN_GAP);

  state_t               state_reg, state_next;
  logic [LEN_W-1:0]     len_reg, len_next;
  logic [DRAIN_W-1:0]   drain_reg, drain_next;
  logic                 trunc_next;

  logic [7:0]           ser_data_reg;
  logic                 ser_valid_reg;
  logic                 ser_start_reg;
  logic [LEN_W-1:0]     ser_length_reg;
  logic                 trunc_reg;
  logic [CNT_W-1:0]     pkt_cnt_reg;

  logic                 accept;
  logic                 keep;
  logic [LEN_W-1:0]     len_inc;

  // Ready depends on state only; it is also forced low while reset is held
  // so nothing is accepted before the loader is out of reset.
  assign s_ready = ~wr_rst & ((state_reg == IDLE) || (state_reg == FILL) ||
                              (state_reg == DISCARD));
  assign accept  = s_valid & s_ready;
  // Bytes accepted in DISCARD are consumed but never forwarded.
  assign keep    = (state_reg == IDLE) || (state_reg == FILL);
  assign len_inc = len_reg + LEN_W'(1);

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    drain_next = drain_reg;
    trunc_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          len_next = LEN_W'(1);
          if (s_last) begin
            state_next = LAUNCH;
          end else if (MAX_LEN_L == LEN_W'(1)) begin
            state_next = DISCARD;
            trunc_next = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          len_next = len_inc;
          // s_last wins over truncation when both land on the MAX_LEN-th byte.
          if (s_last) begin
            state_next = LAUNCH;
          end else if (len_inc == MAX_LEN_L) begin
            state_next = DISCARD;
            trunc_next = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && s_last) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        // Serializer needs len cycles to shift the packet out, then the gap.
        drain_next = {1'b0, len_reg} + GAP_L;
        state_next = DRAIN;
      end
      DRAIN: begin
        drain_next = drain_reg - DRAIN_W'(1);
        if (drain_reg == DRAIN_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      drain_reg      <= '0;
      ser_data_reg   <= '0;
      ser_valid_reg  <= 1'b0;
      ser_start_reg  <= 1'b0;
      ser_length_reg <= '0;
      trunc_reg      <= 1'b0;
      pkt_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      drain_reg     <= drain_next;
      ser_valid_reg <= accept & keep;
      if (accept && keep) begin
        ser_data_reg <= s_data;
      end
      // LAUNCH is entered the cycle the final byte is on ser_valid_o, so the
      // registered start lands exactly one cycle after it.
      ser_start_reg <= (state_reg == LAUNCH);
      if (state_reg == LAUNCH) begin
        ser_length_reg <= len_reg;
        pkt_cnt_reg    <= pkt_cnt_reg + CNT_W'(1);
      end
      trunc_reg <= trunc_next;
    end
  end

  assign ser_data_o   = ser_data_reg;
  assign ser_valid_o  = ser_valid_reg;
  assign ser_start_o  = ser_start_reg;
  assign ser_length_o = ser_length_reg;
  assign trunc_err_o  = trunc_reg;
  assign pkt_cnt_o    = pkt_cnt_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_oserdes_pkt_loader.sv
// ---------------------------------------------------------------------------
// tb_oserdes_pkt_loader
//   Directed and random packets into oserdes_pkt_loader (MAX_LEN=8,
//   DRAIN_GAP=4). Expected results come from a packet-level model: kept
//   bytes = first min(n, MAX_LEN), length = min(n, MAX_LEN), truncation iff
//   n > MAX_LEN, ready low for 1 + length + DRAIN_GAP cycles after the last
//   byte. A negedge monitor collects what the DUT produced.
// ---------------------------------------------------------------------------
module tb_oserdes_pkt_loader;

  localparam int MAX_LEN   = 8;
  localparam int DRAIN_GAP = 4;
  localparam int CNT_W     = 16;

  logic             wr_clk = 1'b0;
  logic             wr_rst = 1'b1;
  logic [7:0]       s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic [7:0]       ser_data_o;
  logic             ser_valid_o;
  logic             ser_start_o;
  logic [7:0]       ser_length_o;
  logic             busy_o;
  logic             trunc_err_o;
  logic [CNT_W-1:0] pkt_cnt_o;

  oserdes_pkt_loader #(
    .MAX_LEN   (MAX_LEN),
    .DRAIN_GAP (DRAIN_GAP),
    .CNT_W     (CNT_W)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst       (wr_rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .ser_data_o   (ser_data_o),
    .ser_valid_o  (ser_valid_o),
    .ser_start_o  (ser_start_o),
    .ser_length_o (ser_length_o),
    .busy_o       (busy_o),
    .trunc_err_o  (trunc_err_o),
    .pkt_cnt_o    (pkt_cnt_o)
  );

  always #5 wr_clk = ~wr_clk;

  int errors = 0;
  int checks = 0;

  // Observed DUT activity, gathered by the monitor.
  logic [7:0] out_q[$];
  int         starts = 0;
  int         truncs = 0;
  int         last_len = 0;
  logic       start_prev_valid = 1'b0;
  logic       prev_valid = 1'b0;

  // Model bookkeeping.
  logic [7:0] pkt_q[$];
  int         exp_pkts = 0;
  int         exp_truncs = 0;

  always @(negedge wr_clk) begin
    if (!wr_rst) begin
      if (ser_valid_o) out_q.push_back(ser_data_o);
      if (ser_start_o) begin
        starts++;
        last_len = int'(ser_length_o);
        start_prev_valid = prev_valid;
      end
      if (trunc_err_o) truncs++;
      prev_valid = ser_valid_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge wr_clk);
  endtask

  // Entered at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int waited = 0;
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    while (!s_ready && waited < 1000) begin
      waited++;
      @(negedge wr_clk);
    end
    if (waited >= 1000) begin
      checks++;
      errors++;
      $error("FAIL accept_wait: observed=timeout expected=accept");
    end
    @(negedge wr_clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends pkt_q as one packet with `gap` idle cycles between bytes and checks
  // it against the packet-level model. With hold set, the next packet's single
  // byte is presented (s_valid high) throughout the drain.
  task automatic run_pkt(input string name, input int gap, input bit hold,
                         input logic [7:0] hold_byte);
    int n, exp_len, lows;
    bit exp_trunc;
    n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) idle(gap);
      send_byte(pkt_q[i], (i == n - 1));
    end
    exp_len   = (n > MAX_LEN) ? MAX_LEN : n;
    exp_trunc = (n > MAX_LEN);
    exp_pkts++;
    if (exp_trunc) exp_truncs++;
    if (hold) begin
      s_data  = hold_byte;
      s_last  = 1'b1;
      s_valid = 1'b1;
    end
    lows = 0;
    while (!s_ready && lows < 1000) begin
      lows++;
      @(negedge wr_clk);
    end
    #1;
    check({name, ".ready_low"}, lows, 1 + exp_len + DRAIN_GAP);
    check({name, ".starts"}, starts, exp_pkts);
    check({name, ".length"}, last_len, exp_len);
    check({name, ".truncs"}, truncs, exp_truncs);
    check({name, ".pkt_cnt"}, 32'(pkt_cnt_o), exp_pkts);
    check({name, ".nbytes"}, out_q.size(), exp_len);
    for (int i = 0; i < exp_len && i < out_q.size(); i++)
      check({name, ".byte"}, out_q[i], pkt_q[i]);
    if (!exp_trunc) check({name, ".start_after_valid"}, start_prev_valid, 1);
    $display("pkt %s: sent=%0d kept=%0d len=%0d trunc=%0d pkt_cnt=%0d",
             name, n, out_q.size(), last_len, truncs, pkt_cnt_o);
    out_q.delete();
    pkt_q.delete();
  endtask

  initial begin
    // Reset state while reset is held.
    repeat (2) @(negedge wr_clk);
    #1;
    check("rst.s_ready", s_ready, 0);
    check("rst.ser_valid", ser_valid_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.pkt_cnt", 32'(pkt_cnt_o), 0);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    #1;
    check("rst.ready_after", s_ready, 1);
    @(negedge wr_clk);

    // 1: four bytes back to back.
    pkt_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    run_pkt("four", 0, 1'b0, 8'h00);
    // 2: single byte.
    pkt_q = '{8'h5A};
    run_pkt("single", 0, 1'b0, 8'h00);
    // 3: 11 bytes, truncated to MAX_LEN.
    for (int i = 0; i < 11; i++) pkt_q.push_back(8'(8'h10 + i));
    run_pkt("trunc11", 0, 1'b0, 8'h00);
    // 4: exactly MAX_LEN with last on final byte.
    for (int i = 0; i < 8; i++) pkt_q.push_back(8'(8'h30 + i));
    run_pkt("exact8", 0, 1'b0, 8'h00);
    // 5: gapped input; next byte held valid during drain.
    pkt_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    run_pkt("gapped", 2, 1'b1, 8'h77);
    pkt_q = '{8'h77};
    run_pkt("held", 0, 1'b0, 8'h00);

    // Random packets.
    for (int p = 0; p < 8; p++) begin
      int len;
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
      run_pkt($sformatf("rand%0d", p), int'($urandom_range(0, 2)), 1'b0, 8'h00);
    end

    // 6: reset in the middle of a packet.
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    #2 wr_rst = 1'b1;
    #1;
    check("midrst.ser_valid", ser_valid_o, 0);
    check("midrst.s_ready", s_ready, 0);
    check("midrst.busy", busy_o, 0);
    check("midrst.start", ser_start_o, 0);
    check("midrst.pkt_cnt", 32'(pkt_cnt_o), 0);
    $display("reset mid-packet: busy=%0d pkt_cnt=%0d", busy_o, pkt_cnt_o);
    repeat (2) @(negedge wr_clk);
    wr_rst = 1'b0;
    #1;
    out_q.delete();
    starts     = 0;
    truncs     = 0;
    exp_pkts   = 0;
    exp_truncs = 0;
    @(negedge wr_clk);
    pkt_q = '{8'hD1, 8'hD2};
    run_pkt("after_rst", 0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
